// File: rtl/srff_bank_arbiter.sv
// Round-robin arbiter sharing one bank of SR flag bits between NREQ requesters.
// The winning command is captured on the grant edge and applied to q on the next edge.
module srff_bank_arbiter #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 8,
  parameter int ECNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   s_mask,
  input  logic [NREQ*WIDTH-1:0]   r_mask,
  output logic [NREQ-1:0]         gnt,
  output logic [WIDTH-1:0]        q,
  output logic                    illegal,
  output logic [ECNT_W-1:0]       illegal_cnt
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: req is a level request. gnt is high for exactly the cycle after
  // the edge that captured the requester's masks; masks must stay stable while
  // req=1 and gnt=0, and the requester drops req in its gnt cycle to avoid a repeat.

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic [PTR_W-1:0] win;
  logic             found;
  logic [NREQ-1:0]  gnt_nxt;
  logic [WIDTH-1:0] s_sel;
  logic [WIDTH-1:0] r_sel;

  logic             valid_m;
  logic [WIDTH-1:0] s_m;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] q_nxt;
  logic             ill_cmd;

  // First set request bit at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_nxt = (win == PTR_W'(NREQ - 1)) ? '0 : win + PTR_W'(1);
    gnt_nxt = '0;
    if (found) gnt_nxt[win] = 1'b1;
    s_sel = s_mask[int'(win)*WIDTH +: WIDTH];
    r_sel = r_mask[int'(win)*WIDTH +: WIDTH];
  end

  // Illegal bits (s=r=1) hold their value, same as s=r=0.
  always_comb begin
    q_nxt   = (q | (s_m & ~r_m)) & ~(r_m & ~s_m);
    ill_cmd = |(s_m & r_m);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      gnt         <= '0;
      valid_m     <= 1'b0;
      s_m         <= '0;
      r_m         <= '0;
      q           <= '0;
      illegal     <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      gnt     <= gnt_nxt;
      valid_m <= found;
      if (found) begin
        s_m <= s_sel;
        r_m <= r_sel;
        ptr <= ptr_nxt;
      end
      if (valid_m) begin
        q       <= q_nxt;
        illegal <= ill_cmd;
        if (ill_cmd && (illegal_cnt != {ECNT_W{1'b1}}))
          illegal_cnt <= illegal_cnt + ECNT_W'(1);
      end else begin
        illegal <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_srff_bank_arbiter.sv
// Directed bench for srff_bank_arbiter: reset, round-robin order, SR apply,
// illegal detection, mid-operation reset and counter saturation.
module tb_srff_bank_arbiter;

  localparam int NREQ   = 4;
  localparam int WIDTH  = 8;
  localparam int ECNT_W = 8;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] s_mask;
  logic [NREQ*WIDTH-1:0] r_mask;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic                  illegal;
  logic [ECNT_W-1:0]     illegal_cnt;

  int total;
  int bad;
  logic [NREQ-1:0] exp_q[$];

  srff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .ECNT_W(ECNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .s_mask      (s_mask),
    .r_mask      (r_mask),
    .gnt         (gnt),
    .q           (q),
    .illegal     (illegal),
    .illegal_cnt (illegal_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // advance one edge, then sample away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int i, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] r);
    s_mask[i*WIDTH +: WIDTH] = s;
    r_mask[i*WIDTH +: WIDTH] = r;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    rst = 1'b0;
  endtask

  // single requester: grant edge then apply edge
  task automatic single_cmd(input int i, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] r);
    set_cmd(i, s, r);
    req = '0;
    req[i] = 1'b1;
    step();
    req = '0;
    step();
  endtask

  initial begin
    logic [NREQ-1:0] g;
    int exp_cnt;
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    req    = '0;
    s_mask = '0;
    r_mask = '0;
    step();
    step();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_q", 32'(q), 32'h0);
    check("rst_ill", 32'(illegal), 32'h0);
    check("rst_cnt", 32'(illegal_cnt), 32'h0);

    // 1: single command from requester 0
    rst = 1'b0;
    set_cmd(0, 8'h0F, 8'h00);
    req = 4'b0001;
    step();
    check("t1_gnt", 32'(gnt), 32'h1);
    check("t1_q_before", 32'(q), 32'h0);
    req = '0;
    step();
    check("t1_q", 32'(q), 32'h0F);
    check("t1_ill", 32'(illegal), 32'h0);
    check("t1_gnt_off", 32'(gnt), 32'h0);

    // 2: round-robin with everyone requesting, pointer freshly reset
    do_reset();
    s_mask = '0;
    r_mask = '0;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    req = 4'b1111;
    while (exp_q.size() > 0) begin
      step();
      g = exp_q.pop_front();
      check("t2_rr", 32'(gnt), 32'(g));
    end
    req = '0;
    step();
    check("t2_idle", 32'(gnt), 32'h0);
    check("t2_q", 32'(q), 32'h0);

    single_cmd(0, 8'h0F, 8'h00);
    check("t3_pre_q", 32'(q), 32'h0F);

    // 3: illegal bit0 holds, bit1 set
    set_cmd(1, 8'h03, 8'h01);
    req = 4'b0010;
    step();
    check("t3_gnt", 32'(gnt), 32'h2);
    req = '0;
    step();
    check("t3_q", 32'(q), 32'h0F);
    check("t3_ill", 32'(illegal), 32'h1);
    check("t3_cnt", 32'(illegal_cnt), 32'h1);
    step();
    check("t3_ill_pulse", 32'(illegal), 32'h0);

    // 4: reset bits 2,3
    single_cmd(2, 8'h00, 8'h0C);
    check("t4_q", 32'(q), 32'h03);
    check("t4_ill", 32'(illegal), 32'h0);
    check("t4_cnt", 32'(illegal_cnt), 32'h1);

    // 5: reset on the apply edge discards the captured command
    set_cmd(3, 8'hFF, 8'h00);
    req = 4'b1000;
    step();
    check("t5_gnt", 32'(gnt), 32'h8);
    rst = 1'b1;
    req = '0;
    step();
    check("t5_q", 32'(q), 32'h0);
    check("t5_gnt0", 32'(gnt), 32'h0);
    check("t5_cnt", 32'(illegal_cnt), 32'h0);
    rst = 1'b0;
    s_mask = '0;
    r_mask = '0;
    req = 4'b1111;
    step();
    check("t5_first", 32'(gnt), 32'h1);
    check("t5_discard", 32'(q), 32'h0);
    req = '0;
    step();
    step();

    // 6: 260 back-to-back illegal commands from requester 0
    single_cmd(0, 8'h01, 8'h00);
    check("t6_pre_q", 32'(q), 32'h01);
    set_cmd(0, 8'h01, 8'h01);
    req = 4'b0001;
    step();
    for (int i = 1; i <= 260; i++) begin
      if (i == 260) req = '0;
      step();
      exp_cnt = (i > 255) ? 255 : i;
      check("t6_cnt", 32'(illegal_cnt), 32'(exp_cnt));
      check("t6_q", 32'(q), 32'h01);
    end
    check("t6_ill_last", 32'(illegal), 32'h1);
    step();
    check("t6_ill_idle", 32'(illegal), 32'h0);
    check("t6_cnt_sat", 32'(illegal_cnt), 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
